// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_pkg
// Brief    : Shared state encoding and default widths for the LBIST sequencer.
// Revision : 1.0
// ============================================================================
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam int c_ERR_BITS = 8;
    localparam int c_PAT_BITS = 16;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clear has priority over inc.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bist_sequencer
// Brief    : Clocked LBIST session sequencer: setup, run, ORA drain, verdict.
// Revision : 1.0
// ============================================================================
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int ERR_BITS     = c_ERR_BITS,
    parameter int PAT_BITS     = c_PAT_BITS,
    parameter int SETUP_CYCLES = 10,
    parameter int DRAIN_CYCLES = 2,
    parameter int ERR_LIMIT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                tpg_end,
    input  logic                ora_res,
    output logic                tpg_reset,
    output logic                tpg_en,
    output logic                cut_reset,
    output logic                fail_inc,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_BITS-1:0] err_count,
    output logic [PAT_BITS-1:0] pat_count
);

    localparam int c_TMR_MAX = (SETUP_CYCLES > DRAIN_CYCLES) ? SETUP_CYCLES : DRAIN_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_SETUP_LAST = c_TMR_W'(SETUP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DRAIN_LAST = c_TMR_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [31:0] c_ERR_LIMIT = ERR_LIMIT;
    localparam bist_state_e c_AFTER_RUN = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

    bist_state_e        r_state;
    bist_state_e        w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic               w_clear;
    logic               w_end_acc;
    logic               w_err_inc;
    logic               w_pat_inc;
    logic               w_limit_hit;

    // Abort freezes both counters so the partial session can be inspected.
    assign w_err_inc   = ora_res && !abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_pat_inc   = !abort && (r_state == ST_RUN);
    assign w_limit_hit = (c_ERR_LIMIT != 32'd0) && (32'(err_count) >= c_ERR_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_end_acc   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_SETUP;
                        w_clear     = 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_timer == c_SETUP_LAST) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (tpg_end) begin
                        w_end_acc   = 1'b1;
                        w_state_nxt = c_AFTER_RUN;
                    end else if (w_limit_hit) begin
                        w_state_nxt = c_AFTER_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (r_timer == c_DRAIN_LAST) w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            tpg_reset <= 1'b1;
            cut_reset <= 1'b1;
            tpg_en    <= 1'b0;
            fail_inc  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= (w_state_nxt != r_state) ? '0 : r_timer + c_TMR_W'(1);
            tpg_reset <= w_state_nxt inside {ST_IDLE, ST_SETUP, ST_DONE};
            cut_reset <= w_state_nxt inside {ST_IDLE, ST_SETUP, ST_DONE};
            tpg_en    <= (w_state_nxt == ST_RUN);
            fail_inc  <= w_err_inc || w_end_acc;
            busy      <= w_state_nxt inside {ST_SETUP, ST_RUN, ST_DRAIN};
            done      <= (w_state_nxt == ST_DONE);
            // Verdict uses the post-edge error count so a last-cycle error is seen.
            pass      <= (w_state_nxt == ST_DONE) && (err_count == '0) && !w_err_inc;
        end
    end

    sat_counter #(.WIDTH(ERR_BITS)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    sat_counter #(.WIDTH(PAT_BITS)) u_pat_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_inc   (w_pat_inc),
        .o_count (pat_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_sequencer
// Brief    : Directed self-checking bench for bist_sequencer (three configs).
// Revision : 1.0
// ============================================================================
module tb_bist_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Default configuration
    logic start = 1'b0, abort = 1'b0, tpg_end = 1'b0, ora_res = 1'b0;
    logic tpg_reset, tpg_en, cut_reset, fail_inc, busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] pat_count;
    logic [6:0]  m_flags;
    assign m_flags = {tpg_reset, cut_reset, tpg_en, fail_inc, busy, done, pass};

    bist_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tpg_end(tpg_end), .ora_res(ora_res),
        .tpg_reset(tpg_reset), .tpg_en(tpg_en), .cut_reset(cut_reset), .fail_inc(fail_inc),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .pat_count(pat_count)
    );

    // Narrow error counter, no drain stage
    logic start_s = 1'b0, abort_s = 1'b0, tpg_end_s = 1'b0, ora_res_s = 1'b0;
    logic tpg_reset_s, tpg_en_s, cut_reset_s, fail_inc_s, busy_s, done_s, pass_s;
    logic [1:0]  err_count_s;
    logic [15:0] pat_count_s;
    logic [6:0]  s_flags;
    assign s_flags = {tpg_reset_s, cut_reset_s, tpg_en_s, fail_inc_s, busy_s, done_s, pass_s};

    bist_sequencer #(.ERR_BITS(2), .SETUP_CYCLES(2), .DRAIN_CYCLES(0)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .tpg_end(tpg_end_s), .ora_res(ora_res_s),
        .tpg_reset(tpg_reset_s), .tpg_en(tpg_en_s), .cut_reset(cut_reset_s), .fail_inc(fail_inc_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s), .pat_count(pat_count_s)
    );

    // Early-abort threshold of two errors
    logic start_l = 1'b0, abort_l = 1'b0, tpg_end_l = 1'b0, ora_res_l = 1'b0;
    logic tpg_reset_l, tpg_en_l, cut_reset_l, fail_inc_l, busy_l, done_l, pass_l;
    logic [7:0]  err_count_l;
    logic [15:0] pat_count_l;
    logic [6:0]  l_flags;
    assign l_flags = {tpg_reset_l, cut_reset_l, tpg_en_l, fail_inc_l, busy_l, done_l, pass_l};

    bist_sequencer #(.SETUP_CYCLES(2), .DRAIN_CYCLES(2), .ERR_LIMIT(2)) dut_lim (
        .clk(clk), .rst(rst), .start(start_l), .abort(abort_l), .tpg_end(tpg_end_l), .ora_res(ora_res_l),
        .tpg_reset(tpg_reset_l), .tpg_en(tpg_en_l), .cut_reset(cut_reset_l), .fail_inc(fail_inc_l),
        .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(err_count_l), .pat_count(pat_count_l)
    );

    // Flag order: tpg_reset cut_reset tpg_en fail_inc busy done pass
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (m_flags !== 7'b1100000) begin
            failures++; $display("FAIL reset_flags: got %b expected %b", m_flags, 7'b1100000);
        end
        checks++;
        if (err_count !== 8'd0 || pat_count !== 16'd0) begin
            failures++; $display("FAIL reset_counts: got err=%0d pat=%0d expected 0/0", err_count, pat_count);
        end
        checks++;
        if (s_flags !== 7'b1100000 || l_flags !== 7'b1100000) begin
            failures++; $display("FAIL reset_other: got %b %b expected 1100000", s_flags, l_flags);
        end
    endtask

    task automatic test_setup();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (m_flags !== 7'b1100100) begin
                failures++; $display("FAIL setup_hold cycle %0d: got %b expected %b", c, m_flags, 7'b1100100);
            end
            ora_res = (c == 3);
            tick();
            ora_res = 1'b0;
        end
        checks++;
        if (m_flags !== 7'b0010100) begin
            failures++; $display("FAIL run_entry cycle 11: got %b expected %b", m_flags, 7'b0010100);
        end
        checks++;
        if (err_count !== 8'd0 || pat_count !== 16'd0) begin
            failures++; $display("FAIL setup_ora_ignored: got err=%0d pat=%0d expected 0/0", err_count, pat_count);
        end
    endtask

    task automatic test_clean_run();
        for (int n = 1; n <= 100; n++) begin
            tpg_end = (n == 100);
            tick();
            tpg_end = 1'b0;
            if (n == 50) begin
                checks++;
                if (pat_count !== 16'd50 || m_flags !== 7'b0010100) begin
                    failures++; $display("FAIL run_mid: got pat=%0d flags=%b expected 50 0010100", pat_count, m_flags);
                end
            end
        end
        checks++;
        if (m_flags !== 7'b0001100 || pat_count !== 16'd100) begin
            failures++; $display("FAIL drain1: got flags=%b pat=%0d expected 0001100 100", m_flags, pat_count);
        end
        tick();
        checks++;
        if (m_flags !== 7'b0000100) begin
            failures++; $display("FAIL drain2: got %b expected %b", m_flags, 7'b0000100);
        end
        tick();
        checks++;
        if (m_flags !== 7'b1100011 || err_count !== 8'd0 || pat_count !== 16'd100) begin
            failures++; $display("FAIL clean_done: got flags=%b err=%0d pat=%0d expected 1100011 0 100",
                                 m_flags, err_count, pat_count);
        end
        tick();
        checks++;
        if (m_flags !== 7'b1100011 || pat_count !== 16'd100) begin
            failures++; $display("FAIL done_hold: got flags=%b pat=%0d expected 1100011 100", m_flags, pat_count);
        end
    endtask

    task automatic test_errors();
        int pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (m_flags !== 7'b1100100 || err_count !== 8'd0 || pat_count !== 16'd0) begin
            failures++; $display("FAIL restart_clear: got flags=%b err=%0d pat=%0d expected 1100100 0 0",
                                 m_flags, err_count, pat_count);
        end
        repeat (10) tick();
        for (int n = 1; n <= 10; n++) begin
            ora_res = (n == 2 || n == 4 || n == 6);
            tpg_end = (n == 10);
            tick();
            ora_res = 1'b0;
            tpg_end = 1'b0;
            if (fail_inc) pulses++;
            if (n == 2) begin
                checks++;
                if (err_count !== 8'd1 || fail_inc !== 1'b1) begin
                    failures++; $display("FAIL err_latency: got err=%0d fail_inc=%b expected 1 1", err_count, fail_inc);
                end
            end
        end
        tick();
        if (fail_inc) pulses++;
        checks++;
        if (err_count !== 8'd3 || m_flags !== 7'b0000100) begin
            failures++; $display("FAIL drain_last: got err=%0d flags=%b expected 3 0000100", err_count, m_flags);
        end
        ora_res = 1'b1;
        tick();
        ora_res = 1'b0;
        if (fail_inc) pulses++;
        checks++;
        if (err_count !== 8'd4 || m_flags !== 7'b1101010) begin
            failures++; $display("FAIL err_done: got err=%0d flags=%b expected 4 1101010", err_count, m_flags);
        end
        ora_res = 1'b1;
        tick();
        ora_res = 1'b0;
        if (fail_inc) pulses++;
        checks++;
        if (err_count !== 8'd4 || m_flags !== 7'b1100010) begin
            failures++; $display("FAIL done_ora_ignored: got err=%0d flags=%b expected 4 1100010", err_count, m_flags);
        end
        checks++;
        if (pulses !== 5) begin
            failures++; $display("FAIL fail_inc_pulses: got %0d expected 5", pulses);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        for (int n = 1; n <= 5; n++) begin
            ora_res = (n == 3);
            tick();
            ora_res = 1'b0;
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (m_flags !== 7'b1100000 || err_count !== 8'd1 || pat_count !== 16'd5) begin
            failures++; $display("FAIL abort_run: got flags=%b err=%0d pat=%0d expected 1100000 1 5",
                                 m_flags, err_count, pat_count);
        end
        tick();
        checks++;
        if (m_flags !== 7'b1100000) begin
            failures++; $display("FAIL abort_beats_start: got %b expected %b", m_flags, 7'b1100000);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (m_flags !== 7'b1100100 || err_count !== 8'd0 || pat_count !== 16'd0) begin
            failures++; $display("FAIL abort_restart: got flags=%b err=%0d pat=%0d expected 1100100 0 0",
                                 m_flags, err_count, pat_count);
        end
        repeat (10) tick();
        for (int n = 1; n <= 3; n++) begin
            start = (n == 2);
            tick();
            start = 1'b0;
        end
        checks++;
        if (m_flags !== 7'b0010100 || pat_count !== 16'd3) begin
            failures++; $display("FAIL start_while_busy: got flags=%b pat=%0d expected 0010100 3", m_flags, pat_count);
        end
        tpg_end = 1'b1;
        tick();
        tpg_end = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (m_flags !== 7'b1100000 || err_count !== 8'd0 || pat_count !== 16'd0) begin
            failures++; $display("FAIL rst_in_drain: got flags=%b err=%0d pat=%0d expected 1100000 0 0",
                                 m_flags, err_count, pat_count);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        tick();
        checks++;
        if (s_flags !== 7'b0010100) begin
            failures++; $display("FAIL sat_run_entry: got %b expected %b", s_flags, 7'b0010100);
        end
        for (int n = 1; n <= 6; n++) begin
            ora_res_s = 1'b1;
            tick();
            ora_res_s = 1'b0;
            exp = (n < 3) ? 2'(n) : 2'd3;
            checks++;
            if (err_count_s !== exp) begin
                failures++; $display("FAIL sat_err after %0d: got %0d expected %0d", n, err_count_s, exp);
            end
        end
        tpg_end_s = 1'b1;
        tick();
        tpg_end_s = 1'b0;
        checks++;
        if (s_flags !== 7'b1101010 || err_count_s !== 2'd3 || pat_count_s !== 16'd7) begin
            failures++; $display("FAIL sat_no_drain_done: got flags=%b err=%0d pat=%0d expected 1101010 3 7",
                                 s_flags, err_count_s, pat_count_s);
        end
    endtask

    task automatic test_err_limit();
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        tick();
        tick();
        ora_res_l = 1'b1;
        tick();
        ora_res_l = 1'b0;
        tick();
        ora_res_l = 1'b1;
        tick();
        ora_res_l = 1'b0;
        checks++;
        if (l_flags !== 7'b0011100 || err_count_l !== 8'd2) begin
            failures++; $display("FAIL lim_second_err: got flags=%b err=%0d expected 0011100 2", l_flags, err_count_l);
        end
        tick();
        checks++;
        if (l_flags !== 7'b0000100) begin
            failures++; $display("FAIL lim_to_drain: got %b expected %b", l_flags, 7'b0000100);
        end
        tick();
        tick();
        checks++;
        if (l_flags !== 7'b1100010 || err_count_l !== 8'd2 || pat_count_l !== 16'd4) begin
            failures++; $display("FAIL lim_done: got flags=%b err=%0d pat=%0d expected 1100010 2 4",
                                 l_flags, err_count_l, pat_count_l);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_setup();
        test_clean_run();
        test_errors();
        test_abort();
        test_saturate();
        test_err_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Synchronous FSM that sequences one LBIST session: holds the TPG and CUT in reset for a setup window, enables pattern generation, drains the ORA pipeline, then reports pass/fail.
- Replaces delay-based start-up sequencing with a restartable, fully clocked sequence.
- Sits between the top-level test request and the TPG, CUT and ORA blocks.
- Owns the saturating error counter and the pattern counter.

Parameters:
- ERR_BITS, 8, width of the error counter.
- PAT_BITS, 16, width of the applied-pattern counter.
- SETUP_CYCLES, 10, number of cycles that tpg_reset and cut_reset are held in SETUP; must be >= 1.
- DRAIN_CYCLES, 2, ORA pipeline depth; ORA results are still counted for this many cycles after the run ends; 0 is legal.
- ERR_LIMIT, 0, early-abort threshold on err_count; 0 disables early abort.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle session request; honoured only in IDLE or DONE.
- abort  in  1  single-cycle cancel; honoured in any state.
- tpg_end  in  1  TPG has issued its final pattern.
- ora_res  in  1  ORA mismatch flag for the current pattern.
- tpg_reset  out  1  holds the TPG in its seed state.
- tpg_en  out  1  advances the TPG by one pattern per cycle.
- cut_reset  out  1  reset to the circuit under test.
- fail_inc  out  1  one-cycle pulse per counted error or per run end (drives the failure-log pointer).
- busy  out  1  high in SETUP, RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid only while done is high; 1 when err_count == 0.
- err_count  out  ERR_BITS  errors counted in the current or last session.
- pat_count  out  PAT_BITS  patterns applied in the current or last session.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, tpg_reset=1, cut_reset=1, tpg_en=0, fail_inc=0, busy=0, done=0, pass=0, err_count=0, pat_count=0.
- States are IDLE, SETUP, RUN, DRAIN, DONE.
- IDLE:
  - tpg_reset and cut_reset stay high.
  - start moves to SETUP on the next cycle.
- SETUP:
  - On entry, err_count, pat_count and the setup timer are cleared.
  - tpg_reset=cut_reset=1 for exactly SETUP_CYCLES cycles, then RUN.
- RUN:
  - tpg_reset=cut_reset=0, tpg_en=1.
  - pat_count increments by 1 each RUN cycle, saturating at all-ones with no wrap.
  - tpg_end moves to DRAIN; tpg_en is low from the first DRAIN cycle.
- DRAIN:
  - tpg_en=0; lasts DRAIN_CYCLES cycles, then DONE.
  - DRAIN_CYCLES=0 goes RUN to DONE directly.
- DONE:
  - done=1; pass=(err_count==0); counts hold.
  - tpg_reset=cut_reset=1.
  - start re-enters SETUP; otherwise DONE is held indefinitely.
- Error counting:
  - ora_res is sampled only in RUN and DRAIN.
  - Each sampled ora_res increments err_count, saturating at 2^ERR_BITS-1.
  - ora_res in IDLE, SETUP or DONE is ignored.
- fail_inc is a registered pulse, one cycle after either:
  - a counted ora_res, or
  - the cycle tpg_end is accepted in RUN.
- Latency: err_count and fail_inc update one cycle after the qualifying ora_res sample.
- Early abort: when ERR_LIMIT != 0 and err_count reaches ERR_LIMIT in RUN, go to DRAIN on the next cycle, as if tpg_end had occurred.
- abort:
  - In any state, next state is IDLE with outputs at their reset values, except err_count and pat_count, which hold for debug.
  - busy, done and pass drop the next cycle.
- Simultaneous events:
  - abort+start: abort wins.
  - tpg_end+ora_res in the same RUN cycle: the error is counted and the FSM moves to DRAIN; fail_inc pulses once.
  - start while busy: ignored.
  - rst overrides all inputs, in any state.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE=0, SETUP=1, RUN=2, DRAIN=3, DONE=4, 3-bit);
  - default widths ERR_BITS=8 and PAT_BITS=16.
- One natural sub-module: sat_counter, a parameterised-width saturating counter with synchronous clear and inc.
  - Instantiated twice, for errors and for patterns.
  - Timers stay inline in the FSM.

Test Plan:
- rst, then start at cycle 0:
  - tpg_reset=cut_reset=1 for exactly 10 cycles;
  - tpg_en=1 from cycle 11;
  - busy=1 throughout.
- Clean run of 100 patterns, tpg_end at the 100th RUN cycle, no ora_res:
  - pat_count=100;
  - done=1 after 2 DRAIN cycles;
  - pass=1, err_count=0.
- ora_res pulsed 3 times in RUN, plus once in the last DRAIN cycle:
  - err_count=4, pass=0;
  - fail_inc pulses 5 times (4 errors + tpg_end).
- ERR_BITS=2 with 6 errors: err_count saturates at 3; no wrap to 0.
- ERR_LIMIT=2: second error causes RUN to move to DRAIN without tpg_end; DONE reached with pass=0.
- Abort and reset cases:
  - abort mid-RUN gives IDLE next cycle with tpg_en=0, tpg_reset=1 and counts held;
  - a following start re-enters SETUP with counts cleared;
  - rst asserted in DRAIN gives all reset values.
